// File: rtl/shift_scheduler.sv
// Game-flow FSM and shift-rate scheduler for the object shifter.
// Optional feature macro: SHIFT_SCHED_PAUSE_EN enables the Pause input and the PAUSED state.
module shift_scheduler #(
  parameter int unsigned PERIOD_INIT      = 50_000_000,
  parameter int unsigned PERIOD_MIN       = 5_000_000,
  parameter int unsigned PERIOD_STEP      = 2_500_000,
  parameter int unsigned DODGES_PER_LEVEL = 8,
  parameter int unsigned CNT_W            = 26
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Start,
  input  logic        Pause,
  input  logic        Collision,
  input  logic        DebrisDodge,
  output logic        ShiftPulse,
  output logic        ObjShifterEnable,
  output logic [3:0]  Level,
  output logic [13:0] Score,
  output logic        GameOver,
  output logic [1:0]  DbgState
);

  // Handshake: there is none; Start/Pause/DebrisDodge are single-cycle strobes sampled
  // on every rising edge, Collision is a level, and every output is a registered value.

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    OVER   = 2'd3
  } state_t;

  localparam int unsigned DW = $clog2(DODGES_PER_LEVEL + 1);
  localparam logic [CNT_W-1:0] P_INIT = CNT_W'(PERIOD_INIT);
  localparam logic [CNT_W-1:0] P_MIN  = CNT_W'(PERIOD_MIN);
  localparam logic [CNT_W-1:0] P_STEP = CNT_W'(PERIOD_STEP);
  localparam logic [DW-1:0]    D_LAST = DW'(DODGES_PER_LEVEL - 1);

`ifdef SHIFT_SCHED_PAUSE_EN
  localparam bit PAUSE_EN = 1'b1;
`else
  localparam bit PAUSE_EN = 1'b0;
`endif

  state_t           state, stateNext;
  logic [CNT_W-1:0] cnt, cntNext;
  logic [CNT_W-1:0] period, periodNext;
  logic [DW-1:0]    dodgeCnt, dodgeNext;
  logic [3:0]       levelNext;
  logic [13:0]      scoreNext;
  logic             pulseNext;
  logic             pauseReq;
  logic [CNT_W:0]   periodDiff;

  assign pauseReq   = PAUSE_EN && Pause;
  // One extra bit so a step larger than the current period shows up as a borrow.
  assign periodDiff = {1'b0, period} - {1'b0, P_STEP};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      cnt              <= '0;
      period           <= P_INIT;
      dodgeCnt         <= '0;
      Level            <= '0;
      Score            <= '0;
      ShiftPulse       <= 1'b0;
      ObjShifterEnable <= 1'b0;
      GameOver         <= 1'b0;
      DbgState         <= IDLE;
    end else begin
      state            <= stateNext;
      cnt              <= cntNext;
      period           <= periodNext;
      dodgeCnt         <= dodgeNext;
      Level            <= levelNext;
      Score            <= scoreNext;
      ShiftPulse       <= pulseNext;
      ObjShifterEnable <= (stateNext != IDLE);
      GameOver         <= (stateNext == OVER);
      DbgState         <= stateNext;
    end
  end

  // The pulse register lines up with the cycle the count reads 0, so the fire decision
  // is taken on the edge where the count steps 1->0; Collision/Pause on that edge cancel it.
  always_comb begin
    stateNext  = state;
    cntNext    = cnt;
    periodNext = period;
    dodgeNext  = dodgeCnt;
    levelNext  = Level;
    scoreNext  = Score;
    pulseNext  = 1'b0;
    case (state)
      IDLE: begin
        if (Start) begin
          stateNext = RUN;
          cntNext   = P_INIT - CNT_W'(1);
        end
      end
      RUN: begin
        cntNext = (cnt == '0) ? period - CNT_W'(1) : cnt - CNT_W'(1);
        if (Collision)     stateNext = OVER;
        else if (pauseReq) stateNext = PAUSED;
        else               pulseNext = (cnt == CNT_W'(1));
      end
      PAUSED: begin
        if (pauseReq) begin
          stateNext = RUN;
          pulseNext = (cnt == '0);
        end
      end
      OVER: begin
        if (Start) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase

    if ((state == RUN || state == PAUSED) && DebrisDodge) begin
      if (Score != 14'd9999) scoreNext = Score + 14'd1;
      if (dodgeCnt == D_LAST) begin
        dodgeNext = '0;
        if (Level != 4'd15) levelNext = Level + 4'd1;
        if (periodDiff[CNT_W] || (periodDiff[CNT_W-1:0] < P_MIN)) periodNext = P_MIN;
        else                                                      periodNext = periodDiff[CNT_W-1:0];
      end else begin
        dodgeNext = dodgeCnt + DW'(1);
      end
    end

    if (stateNext == IDLE) begin
      cntNext    = '0;
      periodNext = P_INIT;
      dodgeNext  = '0;
      levelNext  = '0;
      scoreNext  = '0;
    end
  end

endmodule

// File: tb/tb_shift_scheduler.sv
// Directed self-checking bench for shift_scheduler; covers both SHIFT_SCHED_PAUSE_EN builds.
module tb_shift_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        Start;
  logic        Pause;
  logic        Collision;
  logic        DebrisDodge;
  logic        ShiftPulse;
  logic        ObjShifterEnable;
  logic [3:0]  Level;
  logic [13:0] Score;
  logic        GameOver;
  logic [1:0]  DbgState;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  logic [31:0] exp_q[$];

  shift_scheduler #(
    .PERIOD_INIT(20),
    .PERIOD_MIN(8),
    .PERIOD_STEP(6),
    .DODGES_PER_LEVEL(2),
    .CNT_W(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .Start(Start),
    .Pause(Pause),
    .Collision(Collision),
    .DebrisDodge(DebrisDodge),
    .ShiftPulse(ShiftPulse),
    .ObjShifterEnable(ObjShifterEnable),
    .Level(Level),
    .Score(Score),
    .GameOver(GameOver),
    .DbgState(DbgState)
  );

  // clock/reset block
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  task automatic wait_pulse(input int limit, output int at);
    int n = 0;
    at = -1;
    while (n < limit) begin
      tick();
      n++;
      if (ShiftPulse) begin
        at = cyc;
        break;
      end
    end
  endtask

  // scoreboard: pops expected pulse cycles and checks arrival and one-cycle width
  task automatic expect_pulses(input string tag);
    int at;
    logic [31:0] e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      wait_pulse(60, at);
      check(tag, at, e);
      tick();
      check({tag, "_width"}, {31'd0, ShiftPulse}, 32'd0);
    end
  endtask

  task automatic dodge(input int n);
    DebrisDodge = 1'b1;
    repeat (n) tick();
    DebrisDodge = 1'b0;
  endtask

  task automatic count_pulses(input int n, output int cnt);
    cnt = 0;
    repeat (n) begin
      tick();
      if (ShiftPulse) cnt++;
    end
  endtask

  task automatic press_start();
    Start = 1'b1;
    tick();
    Start = 1'b0;
  endtask

  initial begin
    int np;
    rst = 1'b1; Start = 1'b0; Pause = 1'b0; Collision = 1'b0; DebrisDodge = 1'b0;

    // reset state
    @(negedge clk);
    check("rst_pulse", {31'd0, ShiftPulse}, 32'd0);
    check("rst_enable", {31'd0, ObjShifterEnable}, 32'd0);
    check("rst_level", {28'd0, Level}, 32'd0);
    check("rst_score", {18'd0, Score}, 32'd0);
    check("rst_gameover", {31'd0, GameOver}, 32'd0);
    check("rst_state", {30'd0, DbgState}, 32'd0);
    rst = 1'b0;
    tick();

    // game A: start and base pacing
    Start = 1'b1; cyc = 0;
    tick();
    Start = 1'b0;
    check("start_enable", {31'd0, ObjShifterEnable}, 32'd1);
    check("start_state", {30'd0, DbgState}, 32'd1);
    check("start_pulse", {31'd0, ShiftPulse}, 32'd0);
    exp_q.push_back(20); exp_q.push_back(40); exp_q.push_back(60);
    expect_pulses("pace_init");

    // level-ups: 2 dodges -> period 14, 4 more -> 8 then clamped at 8
    dodge(2);
    exp_q.push_back(80);
    expect_pulses("pace_l0");
    dodge(4);
    check("lvl_score", {18'd0, Score}, 32'd6);
    check("lvl_level", {28'd0, Level}, 32'd3);
    exp_q.push_back(94); exp_q.push_back(102); exp_q.push_back(110);
    expect_pulses("pace_clamp");

    // collision on the edge that would fire the cycle-118 pulse, with a same-cycle dodge
    while (cyc < 117) tick();
    Collision = 1'b1; DebrisDodge = 1'b1;
    tick();
    Collision = 1'b0; DebrisDodge = 1'b0;
    check("col_pulse", {31'd0, ShiftPulse}, 32'd0);
    check("col_gameover", {31'd0, GameOver}, 32'd1);
    check("col_enable", {31'd0, ObjShifterEnable}, 32'd1);
    check("col_state", {30'd0, DbgState}, 32'd3);
    check("col_dodge_counted", {18'd0, Score}, 32'd7);
    dodge(1);
    check("over_score_hold", {18'd0, Score}, 32'd7);
    check("over_level_hold", {28'd0, Level}, 32'd3);
    count_pulses(20, np);
    check("over_no_pulses", np, 32'd0);
    press_start();
    check("idle_state", {30'd0, DbgState}, 32'd0);
    check("idle_score", {18'd0, Score}, 32'd0);
    check("idle_level", {28'd0, Level}, 32'd0);
    check("idle_enable", {31'd0, ObjShifterEnable}, 32'd0);
    check("idle_gameover", {31'd0, GameOver}, 32'd0);

    // game B: pause with a held count of 5
    Start = 1'b1; cyc = 0;
    tick();
    Start = 1'b0;
    while (cyc < 14) tick();
    Pause = 1'b1;
    tick();
    Pause = 1'b0;
`ifdef SHIFT_SCHED_PAUSE_EN
    check("pause_state", {30'd0, DbgState}, 32'd2);
    check("pause_enable", {31'd0, ObjShifterEnable}, 32'd1);
    count_pulses(100, np);
    check("pause_no_pulses", np, 32'd0);
    Pause = 1'b1;
    tick();
    Pause = 1'b0;
    check("resume_state", {30'd0, DbgState}, 32'd1);
    exp_q.push_back(121);
    expect_pulses("resume_pulse");
`else
    check("nopause_state", {30'd0, DbgState}, 32'd1);
    exp_q.push_back(20);
    expect_pulses("nopause_pulse");
    Pause = 1'b1;
    tick();
    Pause = 1'b0;
    exp_q.push_back(40);
    expect_pulses("nopause_pulse2");
`endif
    dodge(3);
    check("b_score", {18'd0, Score}, 32'd3);
    check("b_level", {28'd0, Level}, 32'd1);

    // asynchronous reset between edges
    rst = 1'b1;
    #1;
    check("arst_enable", {31'd0, ObjShifterEnable}, 32'd0);
    check("arst_state", {30'd0, DbgState}, 32'd0);
    check("arst_score", {18'd0, Score}, 32'd0);
    check("arst_level", {28'd0, Level}, 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // game C: saturation
    press_start();
    dodge(40);
    check("sat_level40", {28'd0, Level}, 32'd15);
    check("sat_score40", {18'd0, Score}, 32'd40);
    dodge(9958);
    check("sat_score9998", {18'd0, Score}, 32'd9998);
    dodge(3);
    check("sat_score9999", {18'd0, Score}, 32'd9999);
    check("sat_level_hold", {28'd0, Level}, 32'd15);
    check("sat_running", {30'd0, DbgState}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_scheduler.md
# shift_scheduler

Game-flow controller and pacing scheduler for the object shifter. Sequences the game through idle, run, pause and game-over, drives the shifter's `ShiftPulse` and `ObjShifterEnable`, and accelerates shift rate as the player dodges debris. Sits between the debounced button/collision logic and the object shifter. Consumes the shifter's `DebrisDodge` pulses to keep score and level.

## Interface
- `PERIOD_INIT`, 50_000_000: clock cycles between shift pulses at level 0.
- `PERIOD_MIN`, 5_000_000: floor on the shift period. Must be ≥ 4, because the shifter needs 3 cycles per pulse.
- `PERIOD_STEP`, 2_500_000: period reduction applied per level-up.
- `DODGES_PER_LEVEL`, 8: dodges needed per level-up. Must be ≥ 1.
- `CNT_W`, 26: period counter width. Must hold `PERIOD_INIT`.
- `clk`  in  1: system clock.
- `rst`  in  1: asynchronous, active-high reset.
- `Start`  in  1: one-cycle pulse that starts or restarts the game.
- `Pause`  in  1: one-cycle pulse that toggles pause (see Configuration).
- `Collision`  in  1: level input; high means the player hit debris.
- `DebrisDodge`  in  1: one-cycle pulse from the object shifter.
- `ShiftPulse`  out  1: one-cycle shift request to the object shifter.
- `ObjShifterEnable`  out  1: enable for the object shifter.
- `Level`  out  4: current level, 0..15, saturating.
- `Score`  out  14: dodge count, 0..9999, saturating.
- `GameOver`  out  1: high while in the OVER state.

## Operation
- States: IDLE, RUN, PAUSED, OVER. All outputs are registered.
- **IDLE**
  - `ObjShifterEnable`=0, so the shifter clears its display.
  - Score, Level, dodge counter = 0. Period = `PERIOD_INIT`.
  - `Start` → RUN; period counter loads `PERIOD_INIT-1`.
- **RUN**
  - `ObjShifterEnable`=1. The counter decrements each cycle.
  - At 0: `ShiftPulse`=1 for one cycle, and the counter reloads with current period − 1.
  - `Collision`=1 → OVER. `Pause` → PAUSED. `Start` is ignored.
- **PAUSED**
  - `ObjShifterEnable`=1, so the display is held. No pulses; the counter holds its value.
  - `Pause` → RUN, resuming from the held count. `Collision` is ignored.
- **OVER**
  - `ObjShifterEnable`=1, so the display freezes on the crash. `GameOver`=1, no pulses.
  - Score and Level hold. `Start` → IDLE.
- **Dodge accounting** (RUN or PAUSED only; ignored in IDLE/OVER):
  - Each `DebrisDodge` increments Score (saturating at 9999) and the dodge counter.
  - When the dodge counter reaches `DODGES_PER_LEVEL`, it clears and Level increments (saturating at 15).
  - On level-up, period = max(period − `PERIOD_STEP`, `PERIOD_MIN`). The subtraction is done at CNT_W+1 bits, so there is no underflow wrap.
  - The new period takes effect at the next reload; the running count is not altered.
  - Once Level is 15, the period still clamps correctly.
- **Simultaneous events**
  - `Collision` and counter-zero in the same cycle: no pulse; go to OVER.
  - `DebrisDodge` and `Collision` in the same cycle: the dodge is counted, then the block enters OVER.
  - `Pause` and counter-zero in RUN: no pulse; go to PAUSED with the counter at 0. The pulse fires on the first RUN cycle after resume.
  - `Pause` and `Collision` in RUN: `Collision` wins.

## Timing
- Reset values: state IDLE, `ShiftPulse`=0, `ObjShifterEnable`=0, `Level`=0, `Score`=0, `GameOver`=0. The counter and dodge counter are 0; period = `PERIOD_INIT`.
- Reset asserted mid-game returns the block to IDLE immediately (asynchronous).
- First `ShiftPulse` is asserted exactly `PERIOD_INIT` cycles after the cycle `Start` is sampled.
- Pulse spacing in RUN is exactly the current period, in cycles.
- State transitions take effect on the clock edge after the input is sampled. Outputs reflect the new state in that same cycle.
- Score/Level update on the edge after `DebrisDodge` is sampled.

## Configuration
- `SHIFT_SCHED_PAUSE_EN` defined: `Pause` input and the PAUSED state exist as described.
- Not defined: `Pause` port remains but is ignored. PAUSED is unreachable, and the state register may be narrowed.

## Test plan
Parameters for all scenarios: `PERIOD_INIT`=20, `PERIOD_MIN`=8, `PERIOD_STEP`=6, `DODGES_PER_LEVEL`=2.
- **Reset and start:** `rst` pulse, then `Start` at cycle 0 → all outputs 0 during reset. Enable goes to 1 at cycle 1. `ShiftPulse` at cycles 20, 40, 60, each 1 cycle wide.
- **Level-up clamp:** 6 `DebrisDodge` pulses in RUN → Score=6, Level=3. Pulse spacing is 14 then 8 after the next reloads, never below 8.
- **Collision:** `Collision` raised on the same cycle the counter hits 0 → no pulse, `GameOver`=1, enable stays 1. A later `DebrisDodge` leaves Score unchanged. `Start` → IDLE with Score=0, Level=0, enable=0.
- **Pause** (macro defined): `Pause` at count 5 → no pulses for 100 cycles. Second `Pause` → next pulse exactly 5 cycles after resume. With the macro undefined, `Pause` has no effect on pulse timing.
- **Saturation:** force Score to 9998, then send 3 dodges → Score=9999. Level holds at 15 after 40 dodges.
- **Async reset:** `rst` asserted mid-RUN between clock edges → outputs clear before the next edge, and state is IDLE.
